div_16bit: RTL and testbench
============================

# div_16bit

Sequential 16-bit restoring divider producing quotient and remainder, one bit per cycle, behind a start/busy/done handshake. It is the iterative counterpart to the single-cycle saturating CLA adder/subtractor in the ALU datapath: each iteration is a trial subtract. Overflow and divide-by-zero are reported with the same saturation convention (0x7FFF / 0x8000) as the adder. It sits beside the ALU and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 16, operand/result width. Only 16 is supported; the parameter is kept for the package constants.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `A`  in  16  dividend; sampled on an accepted `start`.
- `B`  in  16  divisor; sampled on an accepted `start`.
- `Q`  out  16  quotient; valid while `done` is high and held until the next accepted `start`.
- `R`  out  16  remainder; valid and held under the same rule as `Q`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `DivZero`  out  1  `B` was 0; valid with `Q` and `R`.
- `Ovfl`  out  1  saturated result; can only be set in signed mode.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with `start` = 1:
  - Latch operands.
  - Clear `DivZero`, `Ovfl`, `Q` and `R`.
  - If `B` == 0: go to DONE. Set `DivZero` = 1, `Q` = 0xFFFF, `R` = `A`.
  - Otherwise: go to RUN with iteration counter = 0.
- RUN, each cycle:
  - Shift {rem[15:0], dvd[15:0]} left by 1.
  - Form the 17-bit difference {carry, rem} − {0, divisor}.
  - If it is non-negative, keep the difference and set the new quotient LSB to 1. Otherwise restore the remainder and set the LSB to 0.
  - Increment the counter. After iteration 15, go to DONE and load `Q`/`R`.
- DONE: `done` is high for this cycle only. The state stays DONE with outputs held until `start`. A `start` in the DONE cycle is accepted (back-to-back operations).
- `start` in RUN is ignored. There is no queueing.
- `rst` in any state:
  - Go to IDLE.
  - Drive `Q` = `R` = 0 and `busy` = `done` = `DivZero` = `Ovfl` = 0.
  - Abort any operation in flight; no `done` is produced for it.
- Arithmetic: the internal remainder is 17 bits so the trial subtract never wraps. The unsigned result satisfies `A` = `Q`·`B` + `R` with `R` < `B`.

## Timing
- Accepted `start` in cycle 0:
  - Normal operation: `busy` high in cycles 1–16, `done` high in cycle 17. Latency is 17 cycles.
  - Divide-by-zero: `done` high in cycle 1, `busy` never asserted.
- Outputs are registered. There is no combinational path from `A`, `B` or `start` to any output.
- Reset value of every output is 0.

## Configuration
- `SIGNED_DIV_EN` defined: `A` and `B` are two's complement.
  - Operand magnitudes are taken in the start cycle; 0x8000 maps to magnitude 0x8000.
  - `Q` is negated if the operand signs differ. `R` takes the sign of `A`.
  - 0x8000 / 0xFFFF gives `Q` = 0x7FFF, `R` = 0, `Ovfl` = 1.
  - `B` = 0 gives `Q` = 0x7FFF if `A` ≥ 0, else 0x8000. `R` = `A`, `DivZero` = 1.
  - Sign correction happens on the DONE transition, so latency is unchanged.
- `SIGNED_DIV_EN` undefined: unsigned only. `Ovfl` is tied to 0.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `DIV_WIDTH` = 16 and the iteration count 16;
  - `SAT_POS` = 16'h7FFF, `SAT_NEG` = 16'h8000, `DIVZ_Q` = 16'hFFFF.
- One combinational sub-module, `div_step`:
  - Inputs: 17-bit partial remainder, dividend MSB, divisor.
  - Outputs: next remainder and quotient bit.
  - It is instantiated once and reused every iteration.

## Test plan
- Unsigned 100 / 7 → `Q` = 14, `R` = 2, `DivZero` = 0. `done` exactly in cycle 17, `busy` high in cycles 1–16.
- 0xFFFF / 0x0001 → `Q` = 0xFFFF, `R` = 0. A second `start` (0x0010 / 0x0003) is applied in the `done` cycle → `Q` = 5, `R` = 1, 17 cycles later.
- 0x1234 / 0 → `done` in cycle 1, `DivZero` = 1, `Q` = 0xFFFF, `R` = 0x1234, `busy` never high.
- `start` pulsed in cycle 5 of 500 / 3 with different operands → ignored. Result is `Q` = 166, `R` = 2 at cycle 17.
- `rst` in cycle 8 of an operation → all outputs 0 in the next cycle and no `done`. A new 9 / 4 then gives `Q` = 2, `R` = 1.
- With `SIGNED_DIV_EN`:
  - −7 / 2 → `Q` = 0xFFFD, `R` = 0xFFFF.
  - 0x8000 / 0xFFFF → `Q` = 0x7FFF, `Ovfl` = 1.
  - −5 / 0 → `Q` = 0x8000, `DivZero` = 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 16-bit restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int ITER_CNT  = 16;

  localparam logic [DIV_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DIV_WIDTH-1:0] SAT_NEG = 16'h8000;
  localparam logic [DIV_WIDTH-1:0] DIVZ_Q  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic                 dvd_msb,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in[DIV_WIDTH-1:0], dvd_msb};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    // rem_in[16] would put the shifted value above 2^17, which always exceeds the divisor
    q_bit   = rem_in[DIV_WIDTH] | ~diff[DIV_WIDTH+1];
    rem_out = q_bit ? diff[DIV_WIDTH:0] : shifted;
  end

endmodule

// File: rtl/div_16bit.sv
// Sequential 16-bit restoring divider with start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands with saturation on overflow.
//
// state   | meaning
// IDLE    | waiting for start, outputs zero since reset
// RUN     | one quotient bit per cycle, busy high
// DONE    | result held; done pulses on entry, start accepted here too
module div_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic             Ovfl
);

  div_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fin, rem_fin, divz_val;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic ovfl_q, ovfl_d;
`endif

  div_step u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
`ifdef SIGNED_DIV_EN
    a_mag    = A[WIDTH-1] ? (~A + 16'd1) : A;
    b_mag    = B[WIDTH-1] ? (~B + 16'd1) : B;
    divz_val = A[WIDTH-1] ? SAT_NEG : SAT_POS;
`else
    a_mag    = A;
    b_mag    = B;
    divz_val = DIVZ_Q;
`endif
    quo_fin = {dvd_q[WIDTH-2:0], step_q};
    rem_fin = step_rem[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = divz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovfl_d  = ovfl_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          q_d    = '0;
          r_d    = '0;
          divz_d = 1'b0;
`ifdef SIGNED_DIV_EN
          qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_d = A[WIDTH-1];
          ovfl_d = 1'b0;
`endif
          if (B == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            divz_d  = 1'b1;
            q_d     = divz_val;
            r_d     = A;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = quo_fin;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER_CNT - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SIGNED_DIV_EN
          // Only a positive quotient of magnitude 0x8000 is unrepresentable (0x8000 / -1)
          if (!qneg_q && quo_fin[WIDTH-1]) begin
            q_d    = SAT_POS;
            r_d    = '0;
            ovfl_d = 1'b1;
          end else begin
            q_d = qneg_q ? (~quo_fin + 16'd1) : quo_fin;
            r_d = rneg_q ? (~rem_fin + 16'd1) : rem_fin;
          end
`else
          q_d = quo_fin;
          r_d = rem_fin;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovfl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovfl_q  <= ovfl_d;
`endif
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign DivZero = divz_q;
`ifdef SIGNED_DIV_EN
  assign Ovfl    = ovfl_q;
`else
  assign Ovfl    = 1'b0;
`endif

endmodule

// File: tb/tb_div_16bit.sv
// Directed testbench for div_16bit; signed vectors run only when SIGNED_DIV_EN is defined.
module tb_div_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] Q, R;
  logic        busy, done, DivZero, Ovfl;

  int total = 0;
  int bad   = 0;

  div_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .DivZero(DivZero), .Ovfl(Ovfl)
  );

  always #5 clk = ~clk;

`ifdef SIGNED_DIV_EN
  localparam logic [15:0] EXP_DZ_POS = 16'h7FFF;
`else
  localparam logic [15:0] EXP_DZ_POS = 16'hFFFF;
`endif

  // Drive start for one edge from the current point; returns #1 after that edge (cycle 1).
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sample at negedges from cycle first_cyc; lat = cycle of done (-1 on timeout).
  task automatic wait_done(input int first_cyc, output int lat, output int busy_cnt);
    lat = -1; busy_cnt = 0;
    for (int c = first_cyc; c < first_cyc + 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({Q, R} !== 32'h0) begin bad++; $display("FAIL reset_qr got=%h want=0", {Q, R}); end
    total++; if ({busy, done, DivZero, Ovfl} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, DivZero, Ovfl}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    @(negedge clk);
    issue(16'd100, 16'd7);
    wait_done(1, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
    total++; if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    total++; if (Q !== 16'd14) begin bad++; $display("FAIL basic_q got=%0d want=14", Q); end
    total++; if (R !== 16'd2) begin bad++; $display("FAIL basic_r got=%0d want=2", R); end
    total++; if ({DivZero, Ovfl} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {DivZero, Ovfl}); end
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    total++; if ({Q, R} !== {16'd14, 16'd2}) begin bad++; $display("FAIL basic_hold got=%h want=000e0002", {Q, R}); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    issue(16'hFFFF, 16'h0001);
    wait_done(1, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL b2b_first_latency got=%0d want=17", lat); end
    total++; if ({Q, R} !== {16'hFFFF, 16'h0000}) begin bad++; $display("FAIL b2b_first_qr got=%h want=ffff0000", {Q, R}); end
    issue(16'h0010, 16'h0003);
    wait_done(1, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL b2b_second_latency got=%0d want=17", lat); end
    total++; if (bc !== 16) begin bad++; $display("FAIL b2b_second_busy got=%0d want=16", bc); end
    total++; if ({Q, R} !== {16'd5, 16'd1}) begin bad++; $display("FAIL b2b_second_qr got=%h want=00050001", {Q, R}); end
  endtask

  task automatic test_divzero;
    int lat, bc;
    @(negedge clk);
    issue(16'h1234, 16'h0000);
    wait_done(1, lat, bc);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b want=0", busy); end
    total++; if (DivZero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", DivZero); end
    total++; if (Q !== EXP_DZ_POS) begin bad++; $display("FAIL dz_q got=%h want=%h", Q, EXP_DZ_POS); end
    total++; if (R !== 16'h1234) begin bad++; $display("FAIL dz_r got=%h want=1234", R); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL dz_after got=%b want=00", {busy, done}); end
  endtask

  task automatic test_start_ignored;
    int lat, bc;
    @(negedge clk);
    issue(16'd500, 16'd3);
    repeat (5) @(negedge clk);
    issue(16'd1000, 16'd7);
    wait_done(6, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL ign_latency got=%0d want=17", lat); end
    total++; if (bc !== 11) begin bad++; $display("FAIL ign_busy got=%0d want=11", bc); end
    total++; if ({Q, R} !== {16'd166, 16'd2}) begin bad++; $display("FAIL ign_qr got=%h want=00a60002", {Q, R}); end
  endtask

  task automatic test_reset_abort;
    int lat, bc, dcnt;
    @(negedge clk);
    issue(16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({Q, R} !== 32'h0) begin bad++; $display("FAIL abort_qr got=%h want=0", {Q, R}); end
    total++; if ({busy, done, DivZero, Ovfl} !== 4'b0) begin bad++; $display("FAIL abort_flags got=%b want=0000", {busy, done, DivZero, Ovfl}); end
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dcnt); end
    issue(16'd9, 16'd4);
    wait_done(1, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL abort_new_latency got=%0d want=17", lat); end
    total++; if ({Q, R} !== {16'd2, 16'd1}) begin bad++; $display("FAIL abort_new_qr got=%h want=00020001", {Q, R}); end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    int lat, bc;
    @(negedge clk);
    issue(16'hFFF9, 16'h0002);
    wait_done(1, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL s_neg7_latency got=%0d want=17", lat); end
    total++; if ({Q, R} !== {16'hFFFD, 16'hFFFF}) begin bad++; $display("FAIL s_neg7_qr got=%h want=fffdffff", {Q, R}); end
    total++; if (Ovfl !== 1'b0) begin bad++; $display("FAIL s_neg7_ovfl got=%b want=0", Ovfl); end
    issue(16'h8000, 16'hFFFF);
    wait_done(1, lat, bc);
    total++; if ({Q, R} !== {16'h7FFF, 16'h0000}) begin bad++; $display("FAIL s_ovfl_qr got=%h want=7fff0000", {Q, R}); end
    total++; if (Ovfl !== 1'b1) begin bad++; $display("FAIL s_ovfl_flag got=%b want=1", Ovfl); end
    issue(16'hFFFB, 16'h0000);
    wait_done(1, lat, bc);
    total++; if (lat !== 1) begin bad++; $display("FAIL s_dz_latency got=%0d want=1", lat); end
    total++; if ({Q, R} !== {16'h8000, 16'hFFFB}) begin bad++; $display("FAIL s_dz_qr got=%h want=8000fffb", {Q, R}); end
    total++; if ({DivZero, Ovfl} !== 2'b10) begin bad++; $display("FAIL s_dz_flags got=%b want=10", {DivZero, Ovfl}); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_divzero();
    test_start_ignored();
    test_reset_abort();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
